// File: rtl/clz_share_arbiter.sv
// -----------------------------------------------------------------------------
// clz_share_arbiter
//
// Shares one external leading-zero counter between two requesters. An operand
// accepted from a requester is driven to the counter for one cycle, the
// (saturated) count is captured, and the result is returned to the owning
// requester with a valid/ready handshake. Only one operation is in flight.
//
// Parameters
//   RR_EN        1: round-robin between the requesters on a tie
//                0: fixed priority, requester 0 wins every tie
//
// Ports
//   clk          clock, all state updates on the rising edge
//   rst_n        asynchronous active-low reset
//   reqN_valid   requester N presents an operand
//   reqN_data    operand whose leading zeros are counted
//   reqN_ready   operand from requester N is accepted this cycle
//   rspN_valid   result for requester N is valid
//   rspN_count   leading-zero count 0..32 (0 when not valid)
//   rspN_ready   requester N consumes the result
//   clz_data     operand driven to the shared counter (0 when not enabled)
//   clz_enable   shared counter enable, high for the single issue cycle
//   clz_count    combinational count returned by the shared counter
//   busy         an operation is in flight
//   err          sticky: the counter returned a value above 32
// -----------------------------------------------------------------------------
module clz_share_arbiter #(
    parameter bit RR_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    input  logic [31:0] req0_data,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [31:0] req1_data,
    output logic        req1_ready,
    output logic        rsp0_valid,
    output logic [5:0]  rsp0_count,
    input  logic        rsp0_ready,
    output logic        rsp1_valid,
    output logic [5:0]  rsp1_count,
    input  logic        rsp1_ready,
    output logic [31:0] clz_data,
    output logic        clz_enable,
    input  logic [31:0] clz_count,
    output logic        busy,
    output logic        err
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        RESP
    } state_e;

    state_e      state_q, state_d;
    logic        last_q, last_d;       // requester served most recently
    logic [31:0] operand_q, operand_d;
    logic        owner_q, owner_d;
    logic [5:0]  result_q, result_d;
    logic        err_q, err_d;

    logic        grant0;
    logic        grant1;

    // Requester 0 wins unless requester 1 is also valid and round-robin says
    // it is requester 1's turn (requester 0 was served last).
    always_comb begin
        grant0 = req0_valid & (~req1_valid | ~RR_EN | last_q);
        grant1 = req1_valid & ~grant0;
    end

    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        operand_d  = operand_q;
        owner_d    = owner_q;
        result_d   = result_q;
        err_d      = err_q;

        req0_ready = 1'b0;
        req1_ready = 1'b0;
        rsp0_valid = 1'b0;
        rsp1_valid = 1'b0;
        rsp0_count = '0;
        rsp1_count = '0;
        clz_enable = 1'b0;
        clz_data   = '0;

        case (state_q)
            IDLE: begin
                // Readys are gated by rst_n so they drop the instant reset
                // asserts, even while a requester is still valid.
                req0_ready = grant0 & rst_n;
                req1_ready = grant1 & rst_n;
                if (req0_ready) begin
                    operand_d = req0_data;
                    owner_d   = 1'b0;
                    state_d   = ISSUE;
                end else if (req1_ready) begin
                    operand_d = req1_data;
                    owner_d   = 1'b1;
                    state_d   = ISSUE;
                end
            end
            ISSUE: begin
                clz_enable = 1'b1;
                clz_data   = operand_q;
                if (clz_count > 32'd32) begin
                    result_d = 6'd32;
                    err_d    = 1'b1;
                end else begin
                    result_d = clz_count[5:0];
                end
                state_d = RESP;
            end
            RESP: begin
                if (owner_q == 1'b0) begin
                    rsp0_valid = 1'b1;
                    rsp0_count = result_q;
                    if (rsp0_ready) begin
                        last_d  = 1'b0;
                        state_d = IDLE;
                    end
                end else begin
                    rsp1_valid = 1'b1;
                    rsp1_count = result_q;
                    if (rsp1_ready) begin
                        last_d  = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            last_q    <= 1'b1;
            operand_q <= '0;
            owner_q   <= 1'b0;
            result_q  <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            operand_q <= operand_d;
            owner_q   <= owner_d;
            result_q  <= result_d;
            err_q     <= err_d;
        end
    end

    assign busy = (state_q != IDLE);
    assign err  = err_q;

endmodule

// File: tb/tb_clz_share_arbiter.sv
// -----------------------------------------------------------------------------
// tb_clz_share_arbiter
//
// Drives one fixed-priority instance (index 0) and one round-robin instance
// (index 1) with the same requester stimulus. Each instance has its own
// emulated leading-zero counter and its own transaction-level reference model;
// accepted operands push the expected response into a per-instance queue that
// a separate monitor drains.
// -----------------------------------------------------------------------------
module tb_clz_share_arbiter;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        req0_valid, req1_valid;
    logic [31:0] req0_data, req1_data;
    logic        rsp0_ready, rsp1_ready;
    logic        force_clz;

    logic        req0_ready [2];
    logic        req1_ready [2];
    logic        rsp0_valid [2];
    logic        rsp1_valid [2];
    logic [5:0]  rsp0_count [2];
    logic [5:0]  rsp1_count [2];
    logic [31:0] clz_data   [2];
    logic        clz_enable [2];
    logic [31:0] clz_count  [2];
    logic        busy       [2];
    logic        err        [2];

    clz_share_arbiter #(.RR_EN(1'b0)) u_fp (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready[0]),
        .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready[0]),
        .rsp0_valid(rsp0_valid[0]), .rsp0_count(rsp0_count[0]), .rsp0_ready(rsp0_ready),
        .rsp1_valid(rsp1_valid[0]), .rsp1_count(rsp1_count[0]), .rsp1_ready(rsp1_ready),
        .clz_data(clz_data[0]), .clz_enable(clz_enable[0]), .clz_count(clz_count[0]),
        .busy(busy[0]), .err(err[0])
    );

    clz_share_arbiter #(.RR_EN(1'b1)) u_rr (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready[1]),
        .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready[1]),
        .rsp0_valid(rsp0_valid[1]), .rsp0_count(rsp0_count[1]), .rsp0_ready(rsp0_ready),
        .rsp1_valid(rsp1_valid[1]), .rsp1_count(rsp1_count[1]), .rsp1_ready(rsp1_ready),
        .clz_data(clz_data[1]), .clz_enable(clz_enable[1]), .clz_count(clz_count[1]),
        .busy(busy[1]), .err(err[1])
    );

    // Emulated shared counter: bit scan, optionally overridden with 40.
    function automatic logic [31:0] clz_by_scan(input logic [31:0] d);
        for (int i = 31; i >= 0; i--) begin
            if (d[i]) return 32'(31 - i);
        end
        return 32'd32;
    endfunction

    always_comb begin
        for (int k = 0; k < 2; k++) begin
            clz_count[k] = force_clz ? 32'd40 : clz_by_scan(clz_data[k]);
        end
    end

    // Reference count from arithmetic: clz(d) = 32 - ceil(log2(d + 1)).
    function automatic logic [5:0] ref_clz(input logic [31:0] d);
        logic [32:0] w;
        w = {1'b0, d} + 33'd1;
        return 6'(32 - $clog2(w));
    endfunction

    // ---------------------------------------------------------------- checking
    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout_fail(input string what);
        n_cmp++;
        n_bad++;
        $display("FAIL timeout_%s: expected event did not occur by %0t", what, $time);
    endtask

    // ---------------------------------------------------------------- scoreboard
    typedef struct {
        logic       owner;
        logic [5:0] count;
    } exp_t;

    exp_t sb0[$];
    exp_t sb1[$];
    int   n_own [2][2];

    function automatic void sb_push(input int k, input exp_t e);
        if (k == 0) sb0.push_back(e); else sb1.push_back(e);
    endfunction

    function automatic int sb_size(input int k);
        if (k == 0) return sb0.size();
        return sb1.size();
    endfunction

    function automatic exp_t sb_front(input int k);
        if (k == 0) return sb0[0];
        return sb1[0];
    endfunction

    function automatic void sb_pop(input int k);
        if (k == 0) void'(sb0.pop_front()); else void'(sb1.pop_front());
    endfunction

    function automatic void sb_saturate_last(input int k);
        if (k == 0) sb0[sb0.size()-1].count = 6'd32;
        else        sb1[sb1.size()-1].count = 6'd32;
    endfunction

    function automatic void sb_clear(input int k);
        if (k == 0) sb0.delete(); else sb1.delete();
    endfunction

    // ---------------------------------------------------------------- model
    // phase: 0 waiting for a request, 1 counter busy, 2 result offered
    int          m_phase [2] = '{0, 0};
    logic        m_last  [2] = '{1'b1, 1'b1};
    logic        m_owner [2] = '{1'b0, 1'b0};
    logic        m_err   [2] = '{1'b0, 1'b0};
    logic [31:0] m_data  [2] = '{32'h0, 32'h0};

    // {grant1, grant0}
    function automatic logic [1:0] exp_grant(input int k);
        if (m_phase[k] != 0 || rst_n !== 1'b1) return 2'b00;
        if (req0_valid && req1_valid) begin
            if (k == 1 && m_last[k] == 1'b0) return 2'b10;
            return 2'b01;
        end
        return {req1_valid, req0_valid};
    endfunction

    task automatic model_step(input int k);
        logic [1:0] g;
        string      tag;
        exp_t       e;
        tag = (k == 1) ? "rr" : "fp";
        g   = exp_grant(k);
        check({tag, ".req_ready"}, {req1_ready[k], req0_ready[k]}, g);
        check({tag, ".busy"}, busy[k], m_phase[k] != 0);
        check({tag, ".clz_enable"}, clz_enable[k], m_phase[k] == 1);
        check({tag, ".clz_data"}, clz_data[k], (m_phase[k] == 1) ? m_data[k] : 32'h0);
        check({tag, ".err"}, err[k], m_err[k]);
        check({tag, ".rsp_valid"}, {rsp1_valid[k], rsp0_valid[k]},
              (m_phase[k] == 2) ? (m_owner[k] ? 2'b10 : 2'b01) : 2'b00);
        if (!(m_phase[k] == 2 && m_owner[k] == 1'b0))
            check({tag, ".rsp0_count_idle"}, rsp0_count[k], 0);
        if (!(m_phase[k] == 2 && m_owner[k] == 1'b1))
            check({tag, ".rsp1_count_idle"}, rsp1_count[k], 0);

        case (m_phase[k])
            0: if (g != 2'b00) begin
                m_owner[k] = g[1];
                m_data[k]  = g[1] ? req1_data : req0_data;
                e.owner    = g[1];
                e.count    = ref_clz(m_data[k]);
                sb_push(k, e);
                m_phase[k] = 1;
            end
            1: begin
                if (force_clz) begin
                    m_err[k] = 1'b1;
                    sb_saturate_last(k);
                end
                m_phase[k] = 2;
            end
            default: if (m_owner[k] ? rsp1_ready : rsp0_ready) begin
                m_last[k]  = m_owner[k];
                m_phase[k] = 0;
            end
        endcase
    endtask

    initial forever begin
        @(negedge clk);
        for (int k = 0; k < 2; k++) model_step(k);
    end

    // ---------------------------------------------------------------- monitor
    task automatic mon_step(input int k);
        exp_t  e;
        string tag;
        tag = (k == 1) ? "rr" : "fp";
        if (rsp0_valid[k] || rsp1_valid[k]) begin
            if (sb_size(k) == 0) begin
                check({tag, ".unexpected_rsp"}, {rsp1_valid[k], rsp0_valid[k]}, 2'b00);
            end else begin
                e = sb_front(k);
                check({tag, ".rsp"},
                      {rsp1_valid[k], rsp0_valid[k], rsp1_valid[k] ? rsp1_count[k] : rsp0_count[k]},
                      {e.owner, ~e.owner, e.count});
                if ((rsp0_valid[k] && rsp0_ready) || (rsp1_valid[k] && rsp1_ready)) begin
                    n_own[k][rsp1_valid[k] ? 1 : 0]++;
                    sb_pop(k);
                end
            end
        end
    endtask

    initial forever begin
        @(negedge clk);
        for (int k = 0; k < 2; k++) mon_step(k);
    end

    // ---------------------------------------------------------------- driver
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_phase(input int k, input int p, input int budget, input string what);
        int c;
        c = 0;
        while (m_phase[k] != p && c < budget) begin
            @(posedge clk);
            #1;
            c++;
        end
        if (m_phase[k] != p) timeout_fail(what);
    endtask

    task automatic wait_idle();
        wait_phase(0, 0, 40, "idle_fp");
        wait_phase(1, 0, 40, "idle_rr");
    endtask

    task automatic txn(input logic v0, input logic [31:0] d0, input logic v1, input logic [31:0] d1);
        req0_valid = v0; req0_data = d0;
        req1_valid = v1; req1_data = d1;
        wait_phase(1, 1, 20, "accept");
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        wait_idle();
    endtask

    task automatic reset_checks();
        for (int k = 0; k < 2; k++) begin
            check("rst.ready", {req1_ready[k], req0_ready[k]}, 0);
            check("rst.rsp_valid", {rsp1_valid[k], rsp0_valid[k]}, 0);
            check("rst.rsp_count", {rsp1_count[k], rsp0_count[k]}, 0);
            check("rst.busy_err_en", {busy[k], err[k], clz_enable[k]}, 0);
            check("rst.clz_data", clz_data[k], 0);
        end
    endtask

    task automatic apply_reset();
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        for (int k = 0; k < 2; k++) begin
            m_phase[k] = 0;
            m_last[k]  = 1'b1;
            m_err[k]   = 1'b0;
            sb_clear(k);
        end
        #1;
        reset_checks();
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    task automatic random_run(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            req0_valid = ($urandom_range(0, 2) != 0);
            req1_valid = ($urandom_range(0, 2) != 0);
            req0_data  = $urandom >> $urandom_range(0, 32);
            req1_data  = $urandom >> $urandom_range(0, 32);
            rsp0_ready = ($urandom_range(0, 3) != 0);
            rsp1_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_data = '0; req1_data = '0;
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
        force_clz = 1'b0;
        for (int k = 0; k < 2; k++) for (int j = 0; j < 2; j++) n_own[k][j] = 0;

        #1 rst_n = 1'b0;
        #2 reset_checks();
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;

        // Single requester, count 16.
        rsp0_ready = 1'b1;
        rsp1_ready = 1'b1;
        txn(1'b1, 32'h0000_8000, 1'b0, 32'h0);

        // Continuous tie: round-robin alternates, fixed priority keeps requester 0.
        for (int k = 0; k < 2; k++) for (int j = 0; j < 2; j++) n_own[k][j] = 0;
        req0_valid = 1'b1; req0_data = 32'h8000_0000;
        req1_valid = 1'b1; req1_data = 32'h0000_0001;
        repeat (24) tick();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        wait_idle();
        check("fp.req1_served", n_own[0][1], 0);
        check("fp.req0_served_enough", n_own[0][0] >= 6, 1);
        check("rr.alternation",
              (n_own[1][1] >= 3) && ((n_own[1][0] - n_own[1][1]) inside {-1, 0, 1}), 1);

        // Response held while the owner is not ready; non-owner ready ignored.
        rsp1_ready = 1'b0;
        rsp0_ready = 1'b1;
        req1_valid = 1'b1; req1_data = 32'h0;
        wait_phase(1, 2, 20, "resp_hold");
        req1_valid = 1'b0;
        repeat (5) tick();
        rsp1_ready = 1'b1;
        wait_idle();

        // Counter returns 40: saturate to 32, err sticky.
        force_clz = 1'b1;
        txn(1'b1, $urandom, 1'b0, 32'h0);
        force_clz = 1'b0;
        random_run(150);
        req0_valid = 1'b0; req1_valid = 1'b0;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        wait_idle();

        // Reset in the middle of a response, with both requesters pending.
        rsp0_ready = 1'b0;
        req0_valid = 1'b1; req0_data = $urandom;
        wait_phase(1, 2, 20, "resp_before_reset");
        req0_valid = 1'b1; req0_data = 32'h0001_0000;
        req1_valid = 1'b1; req1_data = 32'hFFFF_FFFF;
        apply_reset();
        rsp0_ready = 1'b1;
        wait_phase(1, 1, 20, "accept_after_reset");
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        wait_idle();

        random_run(300);

        req0_valid = 1'b0; req1_valid = 1'b0;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        wait_idle();
        tick();
        check("fp.sb_drained", sb_size(0), 0);
        check("rr.sb_drained", sb_size(1), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/clz_share_arbiter.md
CLZ_SHARE_ARBITER -- requirements
Module: clz_share_arbiter

Interface
REQ-001 Parameter RR_EN, default 1, selects arbitration: 1 = round-robin, 0 = fixed priority with requester 0 highest.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 req0_valid / req1_valid  input  1  requester i presents an operand.
REQ-005 req0_data / req1_data  input  32  operand whose leading zeros are counted.
REQ-006 req0_ready / req1_ready  output  1  arbiter accepts the operand from requester i.
REQ-007 rsp0_valid / rsp1_valid  output  1  the result for requester i is valid.
REQ-008 rsp0_count / rsp1_count  output  6  leading-zero count, range 0..32.
REQ-009 rsp0_ready / rsp1_ready  input  1  requester i consumes the result.
REQ-010 clz_data  output  32  operand driven to the shared leading-zero counter.
REQ-011 clz_enable  output  1  enables the shared counter.
REQ-012 clz_count  input  32  combinational count returned by the shared counter.
REQ-013 busy  output  1  high whenever the state is not IDLE.
REQ-014 err  output  1  sticky flag: clz_count was observed above 32.

Function
REQ-015 The FSM SHALL have three states: IDLE, ISSUE and RESP.
REQ-016 IDLE: reqi_ready = 1 only for the granted requester; every other ready stays 0.
REQ-017 Grant rule in IDLE:
- Only one valid: that requester is granted.
- Both valid, RR_EN=1: the requester not served last is granted.
- Both valid, RR_EN=0: requester 0 is granted.
REQ-018 A transfer occurs on a cycle with valid & ready; operand and owner index are then registered and the next state is ISSUE.
REQ-019 ISSUE:
- clz_enable = 1 and clz_data = registered operand, for exactly one cycle.
- At the end of the cycle the result register loads min(clz_count, 32)[5:0].
- Next state is RESP.
REQ-020 If clz_count > 32 in ISSUE, the result SHALL saturate to 32 and err SHALL set; err stays set until reset.
REQ-021 Outside ISSUE, clz_enable = 0 and clz_data = 32'h0.
REQ-022 RESP: rsp<owner>_valid = 1 and rsp<owner>_count = the result register; the non-owner rsp_valid = 0.
REQ-023 The response SHALL hold stable while rsp<owner>_ready = 0.
REQ-024 RESP with rsp<owner>_ready = 1: next state is IDLE and the last-served pointer updates to the owner.
REQ-025 No new operand SHALL be accepted in the same cycle as a response handshake; all readys are 0 outside IDLE.
REQ-026 Latency: accept at edge N -> rsp_valid high from cycle N+2; minimum issue interval 3 cycles.
REQ-027 rspi_ready asserted while requester i is not the owner in RESP SHALL be ignored.
REQ-028 reqi_valid deasserted before a handshake SHALL be allowed and leaves no state change.
REQ-029 Inactive rsp_count outputs SHALL read 6'd0.

Reset
REQ-030 While rst_n = 0, the following SHALL hold immediately and asynchronously:
- state = IDLE; last-served pointer = 1, so requester 0 wins the first tie;
- operand, owner and result registers = 0;
- err = 0; busy = 0; all ready/valid outputs = 0; clz_enable = 0.
REQ-031 Reset asserted in ISSUE or RESP SHALL discard the in-flight operation with no response issued.
REQ-032 After rst_n deasserts, the first acceptance can occur in the first IDLE cycle.

Verification
REQ-033 req0 only, data 32'h0000_8000, rsp0_ready=1 -> rsp0_valid at N+2 with count 16; clz_enable high for 1 cycle only.
REQ-034 Both valid every cycle, RR_EN=1, data0 = 32'h8000_0000 and data1 = 32'h0000_0001 -> grants alternate 0,1,0,1; counts 0 and 31.
REQ-035 Same stimulus with RR_EN=0 -> requester 0 is granted every time; req1 is never granted.
REQ-036 Data 32'h0, rsp1_ready held 0 for 5 cycles -> rsp1_valid/count=32 held stable and busy=1 throughout; IDLE is reached the cycle after ready rises.
REQ-037 Force clz_count = 40 in ISSUE -> count 32 and err=1; err remains 1 until rst_n is pulsed.
REQ-038 rst_n pulled low mid-RESP -> all outputs are 0 immediately; no rsp_valid after release; the next tie grants requester 0.
